// File: rtl/nec_ir_pkg.sv
// nec_ir_pkg: shared FSM encoding, tick-range limits and widths
// for the NEC IR front end (ir_edge_timer, nec_ir_frontend).
package nec_ir_pkg;

  localparam int FRAME_W = 32;
  localparam int DUR_W   = 7;

  localparam logic [DUR_W-1:0] DUR_SAT = 7'd127;

  localparam logic [DUR_W-1:0] LM_MIN = 7'd56;
  localparam logic [DUR_W-1:0] LM_MAX = 7'd72;
  localparam logic [DUR_W-1:0] LS_MIN = 7'd28;
  localparam logic [DUR_W-1:0] LS_MAX = 7'd36;
  localparam logic [DUR_W-1:0] RS_MIN = 7'd12;
  localparam logic [DUR_W-1:0] RS_MAX = 7'd20;
  localparam logic [DUR_W-1:0] BM_MIN = 7'd2;
  localparam logic [DUR_W-1:0] BM_MAX = 7'd6;
  localparam logic [DUR_W-1:0] B0_MIN = 7'd2;
  localparam logic [DUR_W-1:0] B0_MAX = 7'd6;
  localparam logic [DUR_W-1:0] B1_MIN = 7'd9;
  localparam logic [DUR_W-1:0] B1_MAX = 7'd15;

  localparam logic [5:0] EMIT_LAST = 6'd32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_REP_MARK,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_EMIT,
    S_RECOVER
  } state_e;

  function automatic logic in_rng(
    input logic [DUR_W-1:0] d,
    input logic [DUR_W-1:0] lo,
    input logic [DUR_W-1:0] hi
  );
    return (d >= lo) && (d <= hi);
  endfunction

  // Burst slot k (1..32, 32 wraps to 0) -> stored bit index.
  // Fields go out in air order, each byte MSB-first.
  function automatic logic [4:0] burst_idx(
    input logic [4:0] k
  );
    logic [4:0] m;
    m = k - 5'd1;
    return {m[4:3], ~m[2:0]};
  endfunction

endpackage

// File: rtl/nec_ir_frontend_if.sv
// nec_ir_frontend_if: IR input and key-decoder side signals.
// slave = front end (IrIn in; Serial/FrameErr/Busy out).
interface nec_ir_frontend_if;
  logic IrIn;
  logic Serial;
  logic FrameErr;
  logic Busy;

  modport slave (
    input  IrIn,
    output Serial,
    output FrameErr,
    output Busy
  );

  modport master (
    output IrIn,
    input  Serial,
    input  FrameErr,
    input  Busy
  );
endinterface

// File: rtl/ir_edge_timer.sv
// ir_edge_timer: 2-FF sync of raw IR, edge detect, TICK_DIV prescaler
// and saturating 7-bit tick counter. Ports: clk, rst, ir_in -> rise, fall, level, dur, sat.
module ir_edge_timer
  import nec_ir_pkg::*;
#(
  parameter int TICK_DIV = 7031
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ir_in,
  output logic             rise,
  output logic             fall,
  output logic             level,
  output logic [DUR_W-1:0] dur,
  output logic             sat
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  // The edge cycle itself is the first cycle of the new interval,
  // so a level held N*TICK_DIV cycles reads back as exactly N ticks.
  localparam logic [PW-1:0] P_EDGE = PW'((TICK_DIV > 1) ? 1 : 0);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DUR_W-1:0] dur_q, dur_d;

  assign rise  = s2_q & ~prev_q;
  assign fall  = ~s2_q & prev_q;
  assign level = s2_q;
  assign dur   = dur_q;
  assign sat   = (dur_q == DUR_SAT);

  always_comb begin
    s1_d    = ir_in;
    s2_d    = s1_q;
    prev_d  = s2_q;
    presc_d = presc_q;
    dur_d   = dur_q;
    if (rise | fall) begin
      presc_d = P_EDGE;
      dur_d   = '0;
    end else if (presc_q == P_LAST) begin
      presc_d = '0;
      if (!sat) dur_d = dur_q + 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      prev_q  <= 1'b1;
      presc_q <= '0;
      dur_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      prev_q  <= prev_d;
      presc_q <= presc_d;
      dur_q   <= dur_d;
    end
  end

endmodule

// File: rtl/nec_ir_frontend.sv
// nec_ir_frontend: NEC frame capture, replayed as a 33-cycle burst on Serial.
// Ports: Clock, Reset, bus (IrIn in; Serial, FrameErr, Busy out). Option: IR_REPEAT_EN.
module nec_ir_frontend
  import nec_ir_pkg::*;
#(
  parameter int TICK_DIV = 7031
) (
  input logic              Clock,
  input logic              Reset,
  nec_ir_frontend_if.slave bus
);

  logic             rise;
  logic             fall;
  logic             level;
  logic [DUR_W-1:0] dur;
  logic             sat;

  ir_edge_timer #(
    .TICK_DIV(TICK_DIV)
  ) u_timer (
    .clk   (Clock),
    .rst   (Reset),
    .ir_in (bus.IrIn),
    .rise  (rise),
    .fall  (fall),
    .level (level),
    .dur   (dur),
    .sat   (sat)
  );

  state_e             state_q, state_d;
  logic [4:0]         idx_q, idx_d;
  logic [FRAME_W-1:0] rx_q, rx_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [5:0]         ecnt_q, ecnt_d;
  logic               err_q, err_d;
  logic               abort;
`ifdef IR_REPEAT_EN
  logic               fv_q, fv_d;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      idx_q   <= '0;
      rx_q    <= '0;
      frame_q <= '0;
      ecnt_q  <= '0;
      err_q   <= 1'b0;
`ifdef IR_REPEAT_EN
      fv_q    <= 1'b0;
`endif
    end else begin
      idx_q   <= idx_d;
      rx_q    <= rx_d;
      frame_q <= frame_d;
      ecnt_q  <= ecnt_d;
      err_q   <= err_d;
`ifdef IR_REPEAT_EN
      fv_q    <= fv_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rx_d    = rx_q;
    frame_d = frame_q;
    ecnt_d  = ecnt_q;
    err_d   = 1'b0;
    abort   = 1'b0;
`ifdef IR_REPEAT_EN
    fv_d    = fv_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (fall) state_d = S_LEAD_MARK;
      end
      S_LEAD_MARK: begin
        if (rise) begin
          if (in_rng(dur, LM_MIN, LM_MAX))
            state_d = S_LEAD_SPACE;
          else
            abort = 1'b1;
        end else if (sat) begin
          abort = 1'b1;
        end
      end
      S_LEAD_SPACE: begin
        if (fall) begin
          unique case (1'b1)
            in_rng(dur, LS_MIN, LS_MAX): begin
              state_d = S_BIT_MARK;
              idx_d   = '0;
            end
            in_rng(dur, RS_MIN, RS_MAX): begin
`ifdef IR_REPEAT_EN
              state_d = S_REP_MARK;
`else
              state_d = S_RECOVER;
`endif
            end
            default: abort = 1'b1;
          endcase
        end else if (sat) begin
          abort = 1'b1;
        end
      end
`ifdef IR_REPEAT_EN
      S_REP_MARK: begin
        if (rise) begin
          if (!in_rng(dur, BM_MIN, BM_MAX)) begin
            abort = 1'b1;
          end else if (fv_q) begin
            state_d = S_EMIT;
            ecnt_d  = '0;
          end else begin
            state_d = S_RECOVER;
          end
        end else if (sat) begin
          abort = 1'b1;
        end
      end
`endif
      S_BIT_MARK: begin
        if (rise) begin
          if (in_rng(dur, BM_MIN, BM_MAX))
            state_d = S_BIT_SPACE;
          else
            abort = 1'b1;
        end else if (sat) begin
          abort = 1'b1;
        end
      end
      S_BIT_SPACE: begin
        if (fall) begin
          unique case (1'b1)
            in_rng(dur, B0_MIN, B0_MAX): rx_d[idx_q] = 1'b0;
            in_rng(dur, B1_MIN, B1_MAX): rx_d[idx_q] = 1'b1;
            default:                     abort = 1'b1;
          endcase
          if (!abort) begin
            if (idx_q == 5'd31) begin
              state_d = S_EMIT;
              ecnt_d  = '0;
              frame_d = rx_d;
`ifdef IR_REPEAT_EN
              fv_d    = 1'b1;
`endif
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_BIT_MARK;
            end
          end
        end else if (sat) begin
          abort = 1'b1;
        end
      end
      S_EMIT: begin
        if (ecnt_q == EMIT_LAST) state_d = S_RECOVER;
        else                     ecnt_d  = ecnt_q + 1'b1;
      end
      S_RECOVER: begin
        if (level) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_RECOVER;
      err_d   = 1'b1;
    end
  end

  // Slot 0 of EMIT is the start-low cycle; slots 1..32 carry data.
  always_comb begin
    bus.Serial   = 1'b1;
    bus.FrameErr = err_q;
    bus.Busy     = (state_q != S_IDLE);
    if (state_q == S_EMIT) begin
      if (ecnt_q == '0)
        bus.Serial = 1'b0;
      else
        bus.Serial = frame_q[burst_idx(ecnt_q[4:0])];
    end
  end

endmodule

// File: tb/tb_nec_ir_frontend.sv
// tb_nec_ir_frontend: scoreboard bench for nec_ir_frontend, TICK_DIV=4.
// Honours IR_REPEAT_EN when defined for the whole build.
module tb_nec_ir_frontend;

  localparam int TD = 4;
`ifdef IR_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif
  localparam int O_BURST = 0;
  localparam int O_ERR   = 1;
  localparam int O_SIL   = 2;
  localparam int O_REP   = 3;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  nec_ir_frontend_if bus ();

  nec_ir_frontend #(
    .TICK_DIV(TD)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [31:0] bits;
    int          t_edge;
    bit          trunc;
  } exp_t;

  exp_t        q[$];
  exp_t        pend;
  bit          pend_push = 0;
  int          seq[$];
  int          nc = 0;
  int          nf = 0;
  int          cyc = 0;
  int          err_seen = 0;
  int          err_exp = 0;
  int          last_t = 0;
  bit          have_frame = 0;
  logic [31:0] stored = '0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    nc++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int rr(input int lo, input int hi);
    return int'($urandom_range(hi, lo));
  endfunction

  function automatic bit inr(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic int at(input int d[$], input int i);
    return (i < d.size()) ? d[i] : 0;
  endfunction

  function automatic logic [31:0] word(input logic [7:0] a,
                                       input logic [7:0] c);
    return {~c, c, ~a, a};
  endfunction

  // Air word (b0 = LSB) -> burst as read MSB-first: addr, addr_n, cmd, cmd_n.
  function automatic logic [31:0] to_burst(input logic [31:0] fr);
    return {fr[7:0], fr[15:8], fr[23:16], fr[31:24]};
  endfunction

  // Reference: walk the mark/space list through the NEC timing rules.
  function automatic int model(input int d[$], output logic [31:0] fr);
    fr = '0;
    if (!inr(at(d, 0), 56, 72)) return O_ERR;
    if (inr(at(d, 1), 12, 20)) begin
      if (!REP_EN) return O_SIL;
      if (!inr(at(d, 2), 2, 6)) return O_ERR;
      return have_frame ? O_REP : O_SIL;
    end
    if (!inr(at(d, 1), 28, 36)) return O_ERR;
    for (int i = 0; i < 32; i++) begin
      if (!inr(at(d, 2 + 2 * i), 2, 6)) return O_ERR;
      if (inr(at(d, 3 + 2 * i), 2, 6))       fr[i] = 1'b0;
      else if (inr(at(d, 3 + 2 * i), 9, 15)) fr[i] = 1'b1;
      else return O_ERR;
    end
    return O_BURST;
  endfunction

  task automatic record();
    last_t = cyc;
    if (pend_push) begin
      pend.t_edge = cyc;
      q.push_back(pend);
      pend_push = 0;
    end
  endtask

  // Even entries are marks (IrIn=0), odd are spaces; all in ticks.
  task automatic play(input int d[$], input int rec);
    for (int i = 0; i < d.size(); i++) begin
      if (i == rec) record();
      bus.IrIn = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (d[i] * TD) @(negedge Clock);
    end
    if (rec == d.size()) record();
    bus.IrIn = 1'b1;
  endtask

  task automatic gap(input int ticks);
    bus.IrIn = 1'b1;
    repeat (ticks * TD) @(negedge Clock);
  endtask

  task automatic build(input logic [31:0] fr, input int lm, input int ls,
                       input int bm, input int s0, input int s1);
    seq.delete();
    seq.push_back(lm);
    seq.push_back(ls);
    for (int i = 0; i < 32; i++) begin
      seq.push_back(bm);
      seq.push_back(fr[i] ? s1 : s0);
    end
    seq.push_back(2);
  endtask

  task automatic build_rand(input logic [31:0] fr);
    seq.delete();
    seq.push_back(rr(56, 72));
    seq.push_back(rr(28, 36));
    for (int i = 0; i < 32; i++) begin
      seq.push_back(rr(2, 6));
      seq.push_back(fr[i] ? rr(9, 15) : rr(2, 6));
    end
    seq.push_back(2);
  endtask

  // Replace entry p with v and end the train right after it.
  task automatic cut(input int p, input int v);
    seq[p] = v;
    while (seq.size() > p + 1) void'(seq.pop_back());
    if (p % 2 == 1) seq.push_back(4);
  endtask

  task automatic inject(input int p);
    int v;
    if (p == 0)          v = rr(0, 1) ? rr(40, 55) : rr(73, 100);
    else if (p == 1)     v = rr(0, 1) ? rr(21, 27) : rr(37, 50);
    else if (p % 2 == 0) v = rr(7, 9);
    else begin
      v = rr(16, 22);
      if (v > 20) v = v - 14;
    end
    cut(p, v);
  endtask

  task automatic run(input int d[$]);
    logic [31:0] fr;
    int o;
    int rec;
    o = model(d, fr);
    rec = d.size();
    pend_push = 0;
    case (o)
      O_BURST: begin
        stored = to_burst(fr);
        have_frame = 1;
        pend = '{stored, 0, 1'b0};
        pend_push = 1;
        rec = 66;
      end
      O_REP: begin
        pend = '{stored, 0, 1'b0};
        pend_push = 1;
      end
      O_ERR: err_exp++;
      default: ;
    endcase
    play(d, rec);
    gap(25);
    check("frame_err_count", err_seen, err_exp);
    check("queue_drained", q.size(), 0);
  endtask

  initial begin : mon
    logic [31:0] b;
    int t0;
    bit tr;
    exp_t e;
    forever begin
      @(negedge Clock);
      if (!Reset) begin
        if (bus.FrameErr === 1'b1) err_seen++;
        if (bus.Serial === 1'b0) begin
          t0 = cyc;
          b  = '0;
          tr = 0;
          for (int i = 0; i < 32; i++) begin
            @(negedge Clock);
            if (Reset) begin
              tr = 1;
              break;
            end
            b = {b[30:0], bus.Serial};
            check("no_err_in_burst", bus.FrameErr, 0);
          end
          if (!tr) begin
            @(negedge Clock);
            if (!Reset) check("idle_after_burst", bus.Serial, 1);
          end
          if (q.size() == 0) begin
            nc++;
            nf++;
            $display("FAIL unexpected_burst: got %h expected none", b);
          end else begin
            e = q.pop_front();
            check("truncated", tr, e.trunc);
            if (!tr && !e.trunc) begin
              check("burst", b, e.bits);
              check("latency", t0 - e.t_edge, 3);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    bus.IrIn = 1'b1;
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    check("reset_serial", bus.Serial, 1);
    check("reset_frameerr", bus.FrameErr, 0);
    check("reset_busy", bus.Busy, 0);
    Reset = 1'b0;
    gap(5);

    seq = '{64, 16, 4};
    run(seq);

    build(word(8'h00, 8'h45), 64, 32, 4, 4, 12);
    run(seq);
    build(word(8'h00, 8'h45), 56, 28, 2, 2, 15);
    run(seq);
    build(word(8'h00, 8'h45), 64, 32, 4, 4, 12);
    cut(13, 7);
    run(seq);

    seq = '{130};
    err_exp++;
    play(seq, 99);
    check("sat_err", err_seen, err_exp);
    check("sat_busy_held", bus.Busy, 1);
    gap(25);
    check("sat_idle", bus.Busy, 0);

    build(word(8'h00, 8'h16), 64, 32, 4, 4, 12);
    run(seq);
    seq = '{64, 16, 4};
    run(seq);

    build(word(8'h5A, 8'h33), 64, 32, 4, 4, 12);
    pend = '{to_burst(word(8'h5A, 8'h33)), 0, 1'b1};
    pend_push = 1;
    play(seq, 66);
    while (cyc < last_t + 12) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    check("rst_mid_serial", bus.Serial, 1);
    check("rst_mid_busy", bus.Busy, 0);
    Reset = 1'b0;
    have_frame = 0;
    stored = '0;
    gap(25);
    check("rst_mid_err", err_seen, err_exp);
    check("rst_mid_queue", q.size(), 0);
    build(word(8'h00, 8'h0C), 64, 32, 4, 4, 12);
    run(seq);

    for (int k = 0; k < 14; k++) begin
      int r;
      r = rr(0, 9);
      if (r < 2) begin
        seq = '{rr(56, 72), rr(12, 20), (r == 0) ? rr(7, 9) : rr(2, 6)};
      end else begin
        build_rand($urandom());
        if (r < 4) inject(rr(0, 65));
      end
      run(seq);
    end

    gap(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end

endmodule
